// File: rtl/alu_arbiter.sv
// Two-port round-robin front end sharing one combinational ALU, with a single
// registered response stage that routes each result back to its requester.

module alu (
   input  logic [3:0]  code_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o,
   output logic        illegal_o
);
   // Shifts use the full operand 2 as amount; callers mask it when required.
   always_comb begin
      result_o  = '0;
      illegal_o = 1'b0;
      case (code_i)
         4'b0000: result_o = a_i + b_i;
         4'b1000: result_o = a_i - b_i;
         4'b0001: result_o = a_i << b_i;
         4'b0010: result_o = {31'b0, $signed(a_i) < $signed(b_i)};
         4'b1010: result_o = {31'b0, a_i < b_i};
         4'b0100: result_o = a_i ^ b_i;
         4'b0110: result_o = a_i | b_i;
         4'b0111: result_o = a_i & b_i;
         4'b0101: result_o = a_i >> b_i;
         4'b1101: result_o = $signed(a_i) >>> b_i;
         4'b1111: result_o = '0;
         default: illegal_o = 1'b1;
      endcase
   end
endmodule

module alu_arbiter (
   input  logic        clock,
   input  logic        nReset,
   input  logic [1:0]  reqValid,
   output logic [1:0]  reqReady,
   input  logic [3:0]  reqCode0,
   input  logic [3:0]  reqCode1,
   input  logic [31:0] reqA0,
   input  logic [31:0] reqA1,
   input  logic [31:0] reqB0,
   input  logic [31:0] reqB1,
   output logic [1:0]  respValid,
   input  logic [1:0]  respReady,
   output logic [31:0] respResult,
   output logic        respNegative,
   output logic        respZero,
   output logic        respIllegal
);
   logic        stageValid_q, stageValid_d;
   logic        stageOwner_q, stageOwner_d;
   logic        lastGrant_q, lastGrant_d;
   logic [31:0] result_q, result_d;
   logic        negative_q, negative_d;
   logic        zero_q, zero_d;
   logic        illegal_q, illegal_d;

   logic        stageFree;
   logic        grant;
   logic        accept;
   logic [3:0]  aluCode;
   logic [31:0] aluA;
   logic [31:0] rawB;
   logic [31:0] aluB;
   logic [31:0] aluResult;
   logic        aluIllegal;

   always_comb begin
      stageFree = !stageValid_q || respReady[stageOwner_q];
      grant     = (reqValid == 2'b11) ? !lastGrant_q : reqValid[1];
      reqReady  = '0;
      if (nReset && stageFree && (reqValid != 2'b00)) begin
         reqReady[grant] = 1'b1;
      end
   end

   assign accept = |(reqValid & reqReady);

   always_comb begin
      aluCode = grant ? reqCode1 : reqCode0;
      aluA    = grant ? reqA1 : reqA0;
      rawB    = grant ? reqB1 : reqB0;
      aluB    = rawB;
      if (aluCode == 4'b0001 || aluCode == 4'b0101 || aluCode == 4'b1101) begin
         aluB = {27'b0, rawB[4:0]};
      end
   end

   alu u_alu (
      .code_i   (aluCode),
      .a_i      (aluA),
      .b_i      (aluB),
      .result_o (aluResult),
      .illegal_o(aluIllegal)
   );

   // Payload fields are left untouched on a plain drain; only valid drops.
   always_comb begin
      stageValid_d = stageValid_q;
      stageOwner_d = stageOwner_q;
      lastGrant_d  = lastGrant_q;
      result_d     = result_q;
      negative_d   = negative_q;
      zero_d       = zero_q;
      illegal_d    = illegal_q;
      if (accept) begin
         stageValid_d = 1'b1;
         stageOwner_d = grant;
         lastGrant_d  = grant;
         result_d     = aluResult;
         negative_d   = aluResult[31];
         zero_d       = (aluResult == 32'h0);
         illegal_d    = aluIllegal;
      end else if (stageValid_q && respReady[stageOwner_q]) begin
         stageValid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!nReset) begin
         stageValid_q <= 1'b0;
         stageOwner_q <= 1'b0;
         lastGrant_q  <= 1'b1;
         result_q     <= '0;
         negative_q   <= 1'b0;
         zero_q       <= 1'b1;
         illegal_q    <= 1'b0;
      end else begin
         stageValid_q <= stageValid_d;
         stageOwner_q <= stageOwner_d;
         lastGrant_q  <= lastGrant_d;
         result_q     <= result_d;
         negative_q   <= negative_d;
         zero_q       <= zero_d;
         illegal_q    <= illegal_d;
      end
   end

   assign respValid    = {stageValid_q && stageOwner_q, stageValid_q && !stageOwner_q};
   assign respResult   = result_q;
   assign respNegative = negative_q;
   assign respZero     = zero_q;
   assign respIllegal  = illegal_q;
endmodule
